// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the binary-to-Gray conversion for the FIFO controller.
package fifo_pkg;

    localparam int ADDR_W_DEF = 4;

    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int depth_of(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

    localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 32'd1);
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request, RAM-sequencing and status bundle between a FIFO user and fifo_ctrl.
interface fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = 4
);

    localparam int PW = ptr_width(ADDR_W);

    logic              wr_req;
    logic              rd_req;
    logic              clr_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [PW-1:0]     count;
    logic [PW-1:0]     wr_ptr_gray;
    logic [PW-1:0]     rd_ptr_gray;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_req, rd_req, clr_err,
        input  ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, full, empty,
               almost_full, almost_empty, count, wr_ptr_gray, rd_ptr_gray,
               overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req, clr_err,
        output ram_we, ram_waddr, ram_re, ram_raddr, rd_valid, full, empty,
               almost_full, almost_empty, count, wr_ptr_gray, rd_ptr_gray,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit binary pointer with a registered Gray copy, usable on either FIFO side.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [ADDR_W:0] ptr_bin,
    output logic [ADDR_W:0] ptr_bin_nxt,
    output logic [ADDR_W:0] ptr_gray
);

    localparam int PW = ptr_width(ADDR_W);

    logic [PW-1:0] bin_q;
    logic [PW-1:0] gray_q;
    logic [PW-1:0] gray_d;

    // Gray copy is taken from the next value so it changes on the same edge as the binary pointer.
    always_comb begin
        ptr_bin_nxt = bin_q + {{(PW-1){1'b0}}, inc};
        gray_d      = PW'(bin2gray(32'(ptr_bin_nxt)));
    end

    // Pointer and Gray registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= {PW{1'b0}};
            gray_q <= {PW{1'b0}};
        end else begin
            bin_q  <= ptr_bin_nxt;
            gray_q <= gray_d;
        end
    end

    assign ptr_bin  = bin_q;
    assign ptr_gray = gray_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: pointer ownership, RAM enables, occupancy flags and sticky errors.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    fifo_ctrl_if.slave bus
);

    localparam int PW    = ptr_width(ADDR_W);
    localparam int DEPTH = depth_of(ADDR_W);

    logic          wr_acc_s;
    logic          rd_acc_s;
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] wr_nxt_s;
    logic [PW-1:0] wr_gray_s;
    logic [PW-1:0] rd_bin_s;
    logic [PW-1:0] rd_nxt_s;
    logic [PW-1:0] rd_gray_s;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          ptr_msb_unused;

    // Acceptance uses only the registered flags; nothing is accepted while reset is asserted.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (rst) begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end else begin
            wr_acc_s = bus.wr_req & ~full_q;
            rd_acc_s = bus.rd_req & ~empty_q;
        end
    end

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk         (clk),
        .rst         (rst),
        .inc         (wr_acc_s),
        .ptr_bin     (wr_bin_s),
        .ptr_bin_nxt (wr_nxt_s),
        .ptr_gray    (wr_gray_s)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk         (clk),
        .rst         (rst),
        .inc         (rd_acc_s),
        .ptr_bin     (rd_bin_s),
        .ptr_bin_nxt (rd_nxt_s),
        .ptr_gray    (rd_gray_s)
    );

    // Next occupancy is the wrap-aware pointer distance, equal to count + wr_acc - rd_acc.
    always_comb begin
        count_d    = wr_nxt_s - rd_nxt_s;
        full_d     = (count_d == PW'(DEPTH));
        empty_d    = (count_d == {PW{1'b0}});
        af_d       = (count_d >= PW'(AF_LEVEL));
        ae_d       = (count_d <= PW'(AE_LEVEL));
        rd_valid_d = rd_acc_s;
        ovf_d      = (bus.wr_req & full_q)  | (ovf_q & ~bus.clr_err);
        udf_d      = (bus.rd_req & empty_q) | (udf_q & ~bus.clr_err);
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= {PW{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Wrap bits only matter for the distance; the RAM sees the low address bits.
    assign ptr_msb_unused = wr_bin_s[PW-1] ^ rd_bin_s[PW-1];

    assign bus.ram_we       = wr_acc_s;
    assign bus.ram_waddr    = wr_bin_s[ADDR_W-1:0];
    assign bus.ram_re       = rd_acc_s;
    assign bus.ram_raddr    = rd_bin_s[ADDR_W-1:0];
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.wr_ptr_gray  = wr_gray_s;
    assign bus.rd_ptr_gray  = rd_gray_s;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a queue model plus a behavioural RAM; read data is checked by a monitor.
module tb_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.ADDR_W(AW)) bus ();

    fifo_ctrl #(.ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata;
    logic [31:0] wdata;

    // Behavioural RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.ram_re === 1'b1) rdata <= mem[bus.ram_raddr];
        if (bus.ram_we === 1'b1) mem[bus.ram_waddr] <= wdata;
    end

    logic [31:0] mq[$];
    logic [31:0] sb_q[$];
    int          wr_tot = 0;
    int          rd_tot = 0;
    bit          ovf_m = 1'b0;
    bit          udf_m = 1'b0;
    bit          rv_m = 1'b0;
    bit          last_rst = 1'b1;
    logic [4:0]  prev_wg = 5'd0;
    logic [4:0]  prev_rg = 5'd0;
    int          checks = 0;
    int          failures = 0;

    function automatic int gray_of(input int x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs against the model state after the most recent edge.
    task automatic check_regs();
        int n;
        n = mq.size();
        chk("count", 32'(bus.count), n);
        chk("full", 32'(bus.full), 32'(n == DEPTH));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        chk("wr_ptr_gray", 32'(bus.wr_ptr_gray), gray_of(wr_tot % 32));
        chk("rd_ptr_gray", 32'(bus.rd_ptr_gray), gray_of(rd_tot % 32));
        chk("rd_valid", 32'(bus.rd_valid), 32'(rv_m));
        chk("overflow", 32'(bus.overflow), 32'(ovf_m));
        chk("underflow", 32'(bus.underflow), 32'(udf_m));
        if (!last_rst && bus.wr_ptr_gray !== prev_wg)
            chk("wr_gray_one_bit", $countones(bus.wr_ptr_gray ^ prev_wg), 32'd1);
        if (!last_rst && bus.rd_ptr_gray !== prev_rg)
            chk("rd_gray_one_bit", $countones(bus.rd_ptr_gray ^ prev_rg), 32'd1);
        prev_wg = bus.wr_ptr_gray;
        prev_rg = bus.rd_ptr_gray;
    endtask

    task automatic step(input bit wr, input bit rd, input bit clr, input bit r);
        bit wa;
        bit ra;
        @(negedge clk);
        check_regs();
        rst         = r;
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        bus.clr_err = clr;
        wdata       = $urandom;
        wa = !r && wr && (mq.size() != DEPTH);
        ra = !r && rd && (mq.size() != 0);
        #1;
        chk("ram_we", 32'(bus.ram_we), 32'(wa));
        chk("ram_re", 32'(bus.ram_re), 32'(ra));
        if (wa) chk("ram_waddr", 32'(bus.ram_waddr), wr_tot % DEPTH);
        if (ra) chk("ram_raddr", 32'(bus.ram_raddr), rd_tot % DEPTH);
        @(posedge clk);
        if (r) begin
            mq.delete();
            wr_tot = 0;
            rd_tot = 0;
            ovf_m  = 1'b0;
            udf_m  = 1'b0;
            rv_m   = 1'b0;
        end else begin
            ovf_m = (wr && mq.size() == DEPTH) || (ovf_m && !clr);
            udf_m = (rd && mq.size() == 0) || (udf_m && !clr);
            if (ra) begin
                sb_q.push_back(mq.pop_front());
                rd_tot++;
            end
            if (wa) begin
                mq.push_back(wdata);
                wr_tot++;
            end
            rv_m = ra;
        end
        last_rst = r;
    endtask

    // Monitor: each rd_valid must deliver the oldest outstanding expected word.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_data rd_valid with no outstanding read, data=%0h at %0t", rdata, $time);
            end else begin
                chk("rd_data", rdata, sb_q.pop_front());
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.clr_err = 1'b0;
        wdata       = 32'd0;

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Fill to full, then one extra write that must be rejected.
        repeat (17) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Alternating pairs drive both pointers past the wrap.
        repeat (40) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Underflow set, clear, and set racing against clear.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of traffic.
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic: a write-heavy phase then a read-heavy phase.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 70 : 35;
            step($urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 199) == 0);
        end

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_regs();
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
